// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the ID/EX operand stage: datapath width,
// ALU opcode encodings and the shift-opcode classifier.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_SLL     = 4'b0100;
  localparam logic [3:0] ALU_SLTI    = 4'b0101;
  localparam logic [3:0] ALU_SLTIU   = 4'b0110;
  localparam logic [3:0] ALU_XOR     = 4'b0111;
  localparam logic [3:0] ALU_SLL_ALT = 4'b1001;
  localparam logic [3:0] ALU_SRA     = 4'b1101;
  localparam logic [3:0] ALU_SRL     = 4'b1111;

  // Shift opcodes only use the low five bits of operand B as the amount.
  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      ALU_SLL, ALU_SLL_ALT, ALU_SRL, ALU_SRA: is_shift = 1'b1;
      default:                               is_shift = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats the held register
// value; register x0 always reads as zero.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [WIDTH-1:0]  reg_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [WIDTH-1:0]  exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [WIDTH-1:0]  mwb_result,
  output logic [WIDTH-1:0]  operand
);

  // Pick the youngest in-flight producer of rs, else the captured value.
  always_comb begin
    operand = {WIDTH{1'b0}};
    if (rs == {REG_AW{1'b0}}) begin
      operand = {WIDTH{1'b0}};
    end else if (exm_reg_write && (exm_rd != {REG_AW{1'b0}}) && (exm_rd == rs)) begin
      operand = exm_result;
    end else if (mwb_reg_write && (mwb_rd != {REG_AW{1'b0}}) && (mwb_rd == rs)) begin
      operand = mwb_result;
    end else begin
      operand = reg_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select for an RV32 core.
// Holds one decoded instruction behind a valid/ready handshake, stalls on
// load-use hazards, forwards EX/MEM and MEM/WB results to both operands.
// Optional feature macro: STALL_CNT_EN builds a stall-cycle counter;
// without it stall_cnt is tied to zero.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [WIDTH-1:0]  id_pc,
  input  logic [WIDTH-1:0]  id_rs1_data,
  input  logic [WIDTH-1:0]  id_rs2_data,
  input  logic [WIDTH-1:0]  id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [WIDTH-1:0]  exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [WIDTH-1:0]  mwb_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [WIDTH-1:0]  ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] rs1_idx_r;
  logic [REG_AW-1:0] rs2_idx_r;
  logic [WIDTH-1:0]  rs1_data_r;
  logic [WIDTH-1:0]  rs2_data_r;
  logic [WIDTH-1:0]  imm_r;
  logic              alu_src_r;

  logic              load_use_s;
  logic              transfer_s;
  logic              cap_rs1_s;
  logic              cap_rs2_s;
  logic [WIDTH-1:0]  b_fwd_s;
  logic [WIDTH-1:0]  b_sel_s;

  // Hazard detection and handshake: a held load blocks any consumer of its rd.
  always_comb begin
    load_use_s = ex_valid & ex_mem_read & (ex_rd != {REG_AW{1'b0}}) &
                 ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & ~id_alu_src));
    id_ready   = (~ex_valid | ex_ready) & ~load_use_s;
    transfer_s = id_valid & id_ready;
  end

  // While frozen, a retiring MEM/WB write must land in the held source data.
  always_comb begin
    cap_rs1_s = ex_valid & ~ex_ready & mwb_reg_write &
                (mwb_rd != {REG_AW{1'b0}}) & (mwb_rd == rs1_idx_r);
    cap_rs2_s = ex_valid & ~ex_ready & mwb_reg_write &
                (mwb_rd != {REG_AW{1'b0}}) & (mwb_rd == rs2_idx_r);
  end

  // Pipeline register: flush kills, transfer loads, ready drains, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= {WIDTH{1'b0}};
      ex_rd        <= {REG_AW{1'b0}};
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      alu_ctrl     <= ALU_ADD;
      rs1_idx_r    <= {REG_AW{1'b0}};
      rs2_idx_r    <= {REG_AW{1'b0}};
      rs1_data_r   <= {WIDTH{1'b0}};
      rs2_data_r   <= {WIDTH{1'b0}};
      imm_r        <= {WIDTH{1'b0}};
      alu_src_r    <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (transfer_s) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      alu_ctrl     <= id_alu_ctrl;
      rs1_idx_r    <= id_rs1;
      rs2_idx_r    <= id_rs2;
      rs1_data_r   <= id_rs1_data;
      rs2_data_r   <= id_rs2_data;
      imm_r        <= id_imm;
      alu_src_r    <= id_alu_src;
    end else if (ex_ready) begin
      ex_valid     <= 1'b0;
    end else begin
      if (cap_rs1_s) begin
        rs1_data_r <= mwb_result;
      end
      if (cap_rs2_s) begin
        rs2_data_r <= mwb_result;
      end
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_a (
    .rs            (rs1_idx_r),
    .reg_data      (rs1_data_r),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .operand       (alu_a)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_b (
    .rs            (rs2_idx_r),
    .reg_data      (rs2_data_r),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .operand       (b_fwd_s)
  );

  // Operand B: immediate bypasses forwarding; shifts see only the amount.
  always_comb begin
    if (alu_src_r) begin
      b_sel_s = imm_r;
    end else begin
      b_sel_s = b_fwd_s;
    end
    if (is_shift(alu_ctrl)) begin
      alu_b = {{(WIDTH-5){1'b0}}, b_sel_s[4:0]};
    end else begin
      alu_b = b_sel_s;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Count every cycle decode is offering an instruction that is refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (id_valid && !id_ready) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: a vector table run through a
// scoreboard queue, plus directed load-use, HOLD, flush and reset sequences.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_write, id_mem_read, flush;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_a, alu_b, ex_pc, stall_cnt;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read;

  int n_vec = 0;
  int n_err = 0;

`ifdef STALL_CNT_EN
  localparam logic [31:0] EXP_STALL_ONE = 32'd1;
`else
  localparam logic [31:0] EXP_STALL_ONE = 32'd0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic [4:0]  rs1;
    logic [31:0] rs1_data;
    logic [4:0]  rs2;
    logic [31:0] rs2_data;
    logic        alu_src;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        mwb_we;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_res;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] pc;
    logic [4:0]  rd;
  } exp_t;

  vec_t vt[12];
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] pc, input logic [3:0] ctrl,
    input logic [4:0] rs1, input logic [31:0] rs1_data,
    input logic [4:0] rs2, input logic [31:0] rs2_data,
    input logic alu_src, input logic [31:0] imm, input logic [4:0] rd,
    input logic exm_we, input logic [4:0] exm_rd_i, input logic [31:0] exm_res,
    input logic mwb_we, input logic [4:0] mwb_rd_i, input logic [31:0] mwb_res,
    input logic [31:0] exp_a, input logic [31:0] exp_b);
    vec_t v;
    v.pc = pc; v.ctrl = ctrl; v.rs1 = rs1; v.rs1_data = rs1_data;
    v.rs2 = rs2; v.rs2_data = rs2_data; v.alu_src = alu_src; v.imm = imm;
    v.rd = rd; v.exm_we = exm_we; v.exm_rd = exm_rd_i; v.exm_res = exm_res;
    v.mwb_we = mwb_we; v.mwb_rd = mwb_rd_i; v.mwb_res = mwb_res;
    v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  task automatic fwd_idle();
    exm_reg_write = 1'b0; exm_rd = 5'd0; exm_result = 32'd0;
    mwb_reg_write = 1'b0; mwb_rd = 5'd0; mwb_result = 32'd0;
  endtask

  task automatic drive_instr(input logic [31:0] pc, input logic [3:0] ctrl,
                             input logic [4:0] rs1, input logic [31:0] d1,
                             input logic [4:0] rs2, input logic [31:0] d2,
                             input logic src, input logic [31:0] imm,
                             input logic [4:0] rd, input logic mr);
    id_valid = 1'b1; id_pc = pc; id_alu_ctrl = ctrl;
    id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_alu_src = src; id_imm = imm; id_rd = rd;
    id_reg_write = 1'b1; id_mem_read = mr;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drive_instr(32'd0, ALU_ADD, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0);
    id_valid = 1'b0; id_reg_write = 1'b0;
    fwd_idle();

    // Reset state
    @(negedge clk);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
    chk("rst_ex_mem_read", 32'(ex_mem_read), 32'd0);
    chk("rst_ex_pc", ex_pc, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    rst_n = 1'b1;

    // Load-use: LW x5 held, consumer of x5 waits one bubble
    @(negedge clk);
    drive_instr(32'h200, ALU_ADD, 5'd1, 32'd0, 5'd0, 32'd0, 1'b1, 32'd4, 5'd5, 1'b1);
    @(posedge clk); #2;
    drive_instr(32'h204, ALU_ADD, 5'd5, 32'h50, 5'd6, 32'h6, 1'b0, 32'd0, 5'd7, 1'b0);
    @(negedge clk);
    chk("lu_ex_mem_read", 32'(ex_mem_read), 32'd1);
    chk("lu_id_ready", 32'(id_ready), 32'd0);
    id_rs1 = 5'd6; id_rs2 = 5'd5; id_alu_src = 1'b1;
    #1 chk("lu_imm_no_hazard", 32'(id_ready), 32'd1);
    id_rs1 = 5'd5; id_rs2 = 5'd6; id_alu_src = 1'b0;
    #1 chk("lu_restore_stall", 32'(id_ready), 32'd0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_retry_ready", 32'(id_ready), 32'd1);
    chk("lu_stall_cnt", stall_cnt, EXP_STALL_ONE);
    @(posedge clk); #2;
    id_valid = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'h99;
    @(negedge clk);
    chk("lu_issue_valid", 32'(ex_valid), 32'd1);
    chk("lu_issue_pc", ex_pc, 32'h204);
    chk("lu_issue_rd", 32'(ex_rd), 32'd7);
    chk("lu_issue_alu_a", alu_a, 32'h99);
    fwd_idle();

    // Vector table through the scoreboard
    vt[0]  = mk(32'h100, ALU_ADD,     5'd1,  32'd5,        5'd2, 32'd7,        1'b0, 32'd0,        5'd3,  1'b1, 5'd1,  32'd9,     1'b0, 5'd0,  32'd0,     32'd9,        32'd7);
    vt[1]  = mk(32'h104, ALU_ADD,     5'd4,  32'd44,       5'd2, 32'd2,        1'b0, 32'd0,        5'd10, 1'b1, 5'd2,  32'd11,    1'b1, 5'd2,  32'd22,    32'd44,       32'd11);
    vt[2]  = mk(32'h108, ALU_ADD,     5'd0,  32'd55,       5'd6, 32'd66,       1'b0, 32'd0,        5'd11, 1'b1, 5'd0,  32'd99,    1'b1, 5'd0,  32'd99,    32'd0,        32'd66);
    vt[3]  = mk(32'h10C, ALU_SLL,     5'd7,  32'h8000_0000, 5'd9, 32'hFFFF_FF23, 1'b0, 32'd0,       5'd12, 1'b0, 5'd0,  32'd0,     1'b0, 5'd0,  32'd0,     32'h8000_0000, 32'd3);
    vt[4]  = mk(32'h110, ALU_SLL_ALT, 5'd7,  32'd1,        5'd0, 32'd0,        1'b1, 32'hFFFF_FFE5, 5'd13, 1'b0, 5'd0,  32'd0,     1'b0, 5'd0,  32'd0,     32'd1,        32'd5);
    vt[5]  = mk(32'h114, ALU_SRA,     5'd8,  32'hF000_0000, 5'd9, 32'd0,        1'b0, 32'd0,        5'd14, 1'b0, 5'd0,  32'd0,     1'b1, 5'd9,  32'h3F,    32'hF000_0000, 32'h1F);
    vt[6]  = mk(32'h118, ALU_SRL,     5'd3,  32'h10,       5'd0, 32'd0,        1'b1, 32'h0000_0ABF, 5'd15, 1'b0, 5'd0,  32'd0,     1'b0, 5'd0,  32'd0,     32'h10,       32'h1F);
    vt[7]  = mk(32'h11C, ALU_ADD,     5'd1,  32'd1,        5'd2, 32'd2,        1'b1, 32'hFFFF_F800, 5'd16, 1'b1, 5'd2,  32'd123,   1'b1, 5'd2,  32'd456,   32'd1,        32'hFFFF_F800);
    vt[8]  = mk(32'h120, ALU_OR,      5'd5,  32'hAA,       5'd6, 32'h55,       1'b0, 32'd0,        5'd17, 1'b0, 5'd5,  32'hDEAD,  1'b1, 5'd5,  32'hBEEF,  32'hBEEF,     32'h55);
    vt[9]  = mk(32'h124, ALU_SUB,     5'd12, 32'h1000,     5'd13, 32'h0FFF,    1'b0, 32'd0,        5'd18, 1'b1, 5'd14, 32'd7,     1'b1, 5'd31, 32'd8,     32'h1000,     32'h0FFF);
    vt[10] = mk(32'h128, ALU_XOR,     5'd20, 32'd1,        5'd20, 32'd2,       1'b0, 32'd0,        5'd19, 1'b0, 5'd0,  32'd0,     1'b1, 5'd20, 32'hCAFE,  32'hCAFE,     32'hCAFE);
    vt[11] = mk(32'h12C, ALU_SLTIU,   5'd21, 32'd5,        5'd0, 32'd0,        1'b1, 32'hFFFF_FFFF, 5'd20, 1'b1, 5'd21, 32'h77,    1'b1, 5'd21, 32'h88,    32'h77,       32'hFFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      exp_t e;
      drive_instr(vt[i].pc, vt[i].ctrl, vt[i].rs1, vt[i].rs1_data, vt[i].rs2,
                  vt[i].rs2_data, vt[i].alu_src, vt[i].imm, vt[i].rd, 1'b0);
      exm_reg_write = vt[i].exm_we; exm_rd = vt[i].exm_rd; exm_result = vt[i].exm_res;
      mwb_reg_write = vt[i].mwb_we; mwb_rd = vt[i].mwb_rd; mwb_result = vt[i].mwb_res;
      e.a = vt[i].exp_a; e.b = vt[i].exp_b; e.ctrl = vt[i].ctrl;
      e.pc = vt[i].pc; e.rd = vt[i].rd;
      sb.push_back(e);
      @(posedge clk); #2;
      id_valid = 1'b0;
      @(negedge clk);
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL vec%0d_scoreboard: queue empty, expected an entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'd1);
        chk($sformatf("vec%0d_alu_a", i), alu_a, e.a);
        chk($sformatf("vec%0d_alu_b", i), alu_b, e.b);
        chk($sformatf("vec%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(e.ctrl));
        chk($sformatf("vec%0d_pc", i), ex_pc, e.pc);
        chk($sformatf("vec%0d_rd", i), 32'(ex_rd), 32'(e.rd));
      end
    end
    fwd_idle();

    // HOLD for 3 cycles with MEM/WB capture of rs1
    @(negedge clk);
    ex_ready = 1'b0;
    drive_instr(32'h300, ALU_ADD, 5'd8, 32'd1, 5'd9, 32'd2, 1'b0, 32'd0, 5'd4, 1'b0);
    @(posedge clk); #2;
    id_valid = 1'b0;
    @(negedge clk);
    chk("hold_valid", 32'(ex_valid), 32'd1);
    chk("hold_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #2;
    mwb_reg_write = 1'b1; mwb_rd = 5'd8; mwb_result = 32'h1234;
    @(posedge clk); #2;
    fwd_idle();
    @(posedge clk); #2;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("hold_cap_alu_a", alu_a, 32'h1234);
    chk("hold_alu_b", alu_b, 32'd2);
    chk("hold_pc", ex_pc, 32'h300);
    chk("hold_release_valid", 32'(ex_valid), 32'd1);

    // Flush beats a same-cycle transfer
    drive_instr(32'h400, ALU_AND, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 5'd9, 1'b0);
    flush = 1'b1;
    #1 chk("flush_id_ready", 32'(id_ready), 32'd1);
    @(posedge clk); #2;
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
    chk("flush_pc_kept", ex_pc, 32'h300);

    // Flush coinciding with a load-use stall empties the stage
    drive_instr(32'h500, ALU_ADD, 5'd1, 32'd0, 5'd0, 32'd0, 1'b1, 32'd0, 5'd6, 1'b1);
    @(posedge clk); #2;
    drive_instr(32'h504, ALU_ADD, 5'd6, 32'd0, 5'd1, 32'd0, 1'b0, 32'd0, 5'd7, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_lu_id_ready", 32'(id_ready), 32'd0);
    @(posedge clk); #2;
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk("flush_lu_valid", 32'(ex_valid), 32'd0);
    chk("flush_lu_mem_read", 32'(ex_mem_read), 32'd0);

    // Asynchronous reset while in HOLD
    ex_ready = 1'b0;
    drive_instr(32'h600, ALU_ADD, 5'd3, 32'h33, 5'd4, 32'h44, 1'b0, 32'd0, 5'd2, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    @(posedge clk); #3;
    chk("pre_rst_hold_valid", 32'(ex_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    chk("async_rst_stall_cnt", stall_cnt, 32'd0);
    chk("async_rst_pc", ex_pc, 32'd0);
    chk("async_rst_alu_a", alu_a, 32'd0);
    id_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
